serial_pattern_tx: RTL

//  Serial pattern transmitter: the source end of the serial-bit sequence-detector path.

---
 rtl/serial_pattern_tx_if.sv | 17 +
 rtl/serial_pattern_tx.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/serial_pattern_tx_if.sv
// Handshake and serial-output bundle for the pattern transmitter.
// The master drives start/pattern/reps, and the slave (the transmitter) returns the serial stream.
interface serial_pattern_tx_if #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 4
);
  logic             start;
  logic [PAT_W-1:0] pattern;
  logic [CNT_W-1:0] reps;
  logic             ready;
  logic             dout;
  logic             dout_vld;
  logic             done;

  modport master (output start, pattern, reps, input ready, dout, dout_vld, done);
  modport slave  (input start, pattern, reps, output ready, dout, dout_vld, done);
endinterface

// File: rtl/serial_pattern_tx.sv
// Serial pattern transmitter. It shifts a latched pattern out MSB-first for reps+1 frames,
// with GAP idle cycles between frames, and pulses done after the final bit.
module serial_pattern_tx #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 4,
  parameter int GAP   = 1
) (
  input  logic               clk,
  input  logic               rst,
  serial_pattern_tx_if.slave bus
);
  localparam int BIT_W = $clog2(PAT_W);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP} state_t;

  state_t           state, state_nxt;
  logic [PAT_W-1:0] pat_q, sh_q;
  logic [BIT_W-1:0] bit_cnt;
  logic [CNT_W-1:0] frm_cnt;
  logic             accept, last_bit, last_frame, gap_last;
  logic             load_new, load_frame, shift_bit, frame_dec;
  logic             ready_nxt, dout_nxt, vld_nxt, done_nxt;
  logic             ready_p1, dout_p1, vld_p1, done_p1;

  assign accept     = bus.start && ready_p1;
  assign last_bit   = (bit_cnt == BIT_W'(PAT_W - 1));
  assign last_frame = (frm_cnt == '0);

  // State register and registered outputs; only control carries reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      ready_p1 <= 1'b1;
      dout_p1  <= 1'b0;
      vld_p1   <= 1'b0;
      done_p1  <= 1'b0;
    end else begin
      state    <= state_nxt;
      ready_p1 <= ready_nxt;
      dout_p1  <= dout_nxt;
      vld_p1   <= vld_nxt;
      done_p1  <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (accept) state_nxt = S_SEND;
      S_SEND: begin
        if (last_bit) begin
          if (last_frame)   state_nxt = S_IDLE;
          else if (GAP > 0) state_nxt = S_GAP;
        end
      end
      S_GAP:   if (gap_last) state_nxt = S_SEND;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    ready_nxt  = 1'b0;
    dout_nxt   = 1'b0;
    vld_nxt    = 1'b0;
    done_nxt   = 1'b0;
    load_new   = 1'b0;
    load_frame = 1'b0;
    shift_bit  = 1'b0;
    frame_dec  = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept) begin
          load_new = 1'b1;
          dout_nxt = bus.pattern[PAT_W-1];
          vld_nxt  = 1'b1;
        end else begin
          ready_nxt = 1'b1;
        end
      end
      S_SEND: begin
        if (!last_bit) begin
          shift_bit = 1'b1;
          dout_nxt  = sh_q[PAT_W-1];
          vld_nxt   = 1'b1;
        end else if (last_frame) begin
          ready_nxt = 1'b1;
          done_nxt  = 1'b1;
        end else begin
          frame_dec = 1'b1;
          // Without a gap the next frame's MSB follows the current LSB directly
          if (GAP == 0) begin
            load_frame = 1'b1;
            dout_nxt   = pat_q[PAT_W-1];
            vld_nxt    = 1'b1;
          end
        end
      end
      S_GAP: begin
        if (gap_last) begin
          load_frame = 1'b1;
          dout_nxt   = pat_q[PAT_W-1];
          vld_nxt    = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Datapath: latched pattern, shifter and counters; only meaningful outside IDLE
  always_ff @(posedge clk) begin
    if (load_new) begin
      pat_q   <= bus.pattern;
      sh_q    <= {bus.pattern[PAT_W-2:0], 1'b0};
      frm_cnt <= bus.reps;
      bit_cnt <= '0;
    end else begin
      if (load_frame) begin
        sh_q    <= {pat_q[PAT_W-2:0], 1'b0};
        bit_cnt <= '0;
      end else if (shift_bit) begin
        sh_q    <= {sh_q[PAT_W-2:0], 1'b0};
        bit_cnt <= bit_cnt + BIT_W'(1);
      end
      if (frame_dec) frm_cnt <= frm_cnt - CNT_W'(1);
    end
  end

  generate
    if (GAP > 0) begin : gen_gap
      localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;
      logic [GAP_W-1:0] gap_cnt;
      always_ff @(posedge clk) begin
        if (state != S_GAP) gap_cnt <= '0;
        else                gap_cnt <= gap_cnt + GAP_W'(1);
      end
      assign gap_last = (gap_cnt == GAP_W'(GAP - 1));
    end else begin : gen_nogap
      assign gap_last = 1'b0;
    end
  endgenerate

  assign bus.ready    = ready_p1;
  assign bus.dout     = dout_p1;
  assign bus.dout_vld = vld_p1;
  assign bus.done     = done_p1;
endmodule
